// File: rtl/paralelo_serial_tx.sv
// -----------------------------------------------------------------------------
// paralelo_serial_tx
//   Parallel-to-serial transmitter. After reset it sends SYNC_BYTES comma
//   characters so the receiver can align, then sends data bytes offered on
//   data_in/valid_in. When no byte is offered it fills the slot with IDLE_CH.
//   Bytes go out MSB first and back to back, with no gap bits.
//
// Ports
//   clk_32f   in   bit clock; all state updates on its rising edge
//   reset     in   asynchronous, active-high
//   data_in   in   [7:0] byte offered for transmission
//   valid_in  in   data_in holds a byte to send
//   data_out  out  registered serial bit stream, MSB first
//   ack       out  data_in is consumed at the end of this cycle (combinational)
//   active    out  high once alignment is done (ACTIVE state)
//   idle_tx   out  high while the byte being serialized is an IDLE_CH filler
// -----------------------------------------------------------------------------
module paralelo_serial_tx #(
  parameter int         SYNC_BYTES = 4,      // 1..7
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter logic [7:0] IDLE_CH    = 8'h7C
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       data_out,
  output logic       ack,
  output logic       active,
  output logic       idle_tx
);

  typedef enum logic {SYNC, ACTIVE} state_t;

  localparam logic [2:0] SYNC_LAST = 3'(SYNC_BYTES);

  state_t     state_q, state_d;
  logic [7:0] cur_byte_q, cur_byte_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] sync_cnt_q, sync_cnt_d;
  logic       data_out_q, data_out_d;
  logic       idle_q, idle_d;

  logic boundary;
  logic take_slot;

  // The last comma byte's boundary already behaves like ACTIVE, so the
  // first data/idle byte follows the final comma with no gap.
  assign boundary  = (bit_cnt_q == 3'd7);
  assign take_slot = (state_q == ACTIVE) || (sync_cnt_q == SYNC_LAST);
  assign ack       = valid_in & boundary & take_slot;

  always_comb begin
    state_d    = state_q;
    cur_byte_d = cur_byte_q;
    sync_cnt_d = sync_cnt_q;
    idle_d     = idle_q;
    data_out_d = cur_byte_q[3'd7 - bit_cnt_q];
    bit_cnt_d  = bit_cnt_q + 3'd1;

    if (boundary) begin
      if (take_slot) begin
        state_d = ACTIVE;
        if (valid_in) begin
          cur_byte_d = data_in;
          idle_d     = 1'b0;
        end else begin
          cur_byte_d = IDLE_CH;
          idle_d     = 1'b1;
        end
      end else begin
        cur_byte_d = COMMA;
        sync_cnt_d = sync_cnt_q + 3'd1;
        idle_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q    <= SYNC;
      cur_byte_q <= COMMA;
      bit_cnt_q  <= 3'd0;
      sync_cnt_q <= 3'd1;
      data_out_q <= 1'b0;
      idle_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_byte_q <= cur_byte_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      data_out_q <= data_out_d;
      idle_q     <= idle_d;
    end
  end

  assign data_out = data_out_q;
  assign idle_tx  = idle_q;
  assign active   = (state_q == ACTIVE);

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_paralelo_serial_tx
//   Directed bench for paralelo_serial_tx with default parameters
//   (SYNC_BYTES=4, COMMA=BC, IDLE_CH=7C). Cycle c is the period after the
//   c-th rising edge following reset release; outputs are sampled 1 time
//   unit after each edge. Byte j of the stream is bits 8j+1 .. 8j+8.
// -----------------------------------------------------------------------------
module tb_paralelo_serial_tx;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       data_out, ack, active, idle_tx;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic bits [0:255];
  logic ackv [0:255];
  logic idlv [0:255];
  logic actv [0:255];

  paralelo_serial_tx dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (data_in),
    .valid_in(valid_in),
    .data_out(data_out),
    .ack     (ack),
    .active  (active),
    .idle_tx (idle_tx)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_32f);
    #1;
    cyc++;
    bits[cyc] = data_out;
    ackv[cyc] = ack;
    idlv[cyc] = idle_tx;
    actv[cyc] = active;
  endtask

  function automatic logic [7:0] get_byte(input int j);
    logic [7:0] v = 8'h00;
    for (int b = 0; b < 8; b++) v = {v[6:0], bits[8*j + 1 + b]};
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk_32f);
    @(posedge clk_32f);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin : main
    logic [7:0] tbl [0:2];
    int   idx, nack, first_ack;
    logic pending, idle_seen;

    // ---------------- reset state
    #2;
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_ack",      32'(ack),      0);
    chk("rst_active",   32'(active),   0);
    chk("rst_idle",     32'(idle_tx),  0);

    // ---------------- idle only: 4x BC then 7C
    valid_in = 1'b0;
    do_reset();
    repeat (96) step();
    for (int j = 0; j < 4; j++)  chk($sformatf("sync_byte%0d", j), 32'(get_byte(j)), 32'hBC);
    for (int j = 4; j < 12; j++) chk($sformatf("idle_byte%0d", j), 32'(get_byte(j)), 32'h7C);
    chk("t1_active_c31", 32'(actv[31]), 0);
    chk("t1_active_c32", 32'(actv[32]), 1);
    chk("t1_idle_c31",   32'(idlv[31]), 0);
    chk("t1_idle_c33",   32'(idlv[33]), 1);

    // ---------------- A5 held from reset
    valid_in = 1'b1;
    data_in  = 8'hA5;
    do_reset();
    repeat (41) step();
    nack = 0; first_ack = -1;
    for (int c = 1; c <= 38; c++)
      if (ackv[c]) begin
        nack++;
        if (first_ack < 0) first_ack = c;
      end
    chk("t2_ack_count", 32'(nack), 1);
    chk("t2_ack_cycle", 32'(first_ack), 31);
    chk("t2_byte4",     32'(get_byte(4)), 32'hA5);

    // ---------------- back to back 01, FF, 3C
    tbl[0] = 8'h01; tbl[1] = 8'hFF; tbl[2] = 8'h3C;
    idx = 0; pending = 1'b0; nack = 0;
    valid_in = 1'b1;
    data_in  = tbl[0];
    do_reset();
    repeat (60) begin
      step();
      if (pending) begin
        idx++;
        if (idx < 3) data_in = tbl[idx];
        else valid_in = 1'b0;
        pending = 1'b0;
      end
      if (ackv[cyc]) begin
        nack++;
        pending = 1'b1;
      end
    end
    chk("t3_ack_count", 32'(nack), 3);
    chk("t3_byte4", 32'(get_byte(4)), 32'h01);
    chk("t3_byte5", 32'(get_byte(5)), 32'hFF);
    chk("t3_byte6", 32'(get_byte(6)), 32'h3C);
    idle_seen = 1'b0;
    for (int c = 32; c <= 55; c++) idle_seen |= idlv[c];
    chk("t3_idle_during_data", 32'(idle_seen), 0);
    chk("t3_idle_after_data",  32'(idlv[57]), 1);

    // ---------------- alternating data/idle, BC as data, then mid-byte reset
    valid_in = 1'b0;
    do_reset();
    while (cyc < 68) begin
      step();
      case (cyc)
        24: begin valid_in = 1'b1; data_in = 8'hBC; end
        32: valid_in = 1'b0;
        40: begin valid_in = 1'b1; data_in = 8'hA5; end
        48: valid_in = 1'b0;
        56: begin valid_in = 1'b1; data_in = 8'hF0; end
        64: valid_in = 1'b0;
        default: ;
      endcase
    end
    chk("t4_byte4", 32'(get_byte(4)), 32'hBC);
    chk("t4_byte5", 32'(get_byte(5)), 32'h7C);
    chk("t4_byte6", 32'(get_byte(6)), 32'hA5);
    chk("t4_byte7", 32'(get_byte(7)), 32'h7C);
    chk("t4_idle_slot4", 32'(idlv[33]), 0);
    chk("t4_idle_slot5", 32'(idlv[41]), 1);
    chk("t4_idle_slot6", 32'(idlv[49]), 0);
    chk("t4_idle_slot7", 32'(idlv[57]), 1);
    chk("t4_active_c68", 32'(actv[68]), 1);
    // cycle 68: bit_cnt==4 inside F0, current bit is F0[4]=1
    chk("t4_bit_before_rst", 32'(bits[68]), 1);

    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_data_out", 32'(data_out), 0);
    chk("t5_rst_active",   32'(active),   0);
    chk("t5_rst_idle",     32'(idle_tx),  0);
    chk("t5_rst_ack",      32'(ack),      0);
    do_reset();
    repeat (40) step();
    for (int j = 0; j < 4; j++) chk($sformatf("t5_sync_byte%0d", j), 32'(get_byte(j)), 32'hBC);
    chk("t5_active_c31", 32'(actv[31]), 0);
    chk("t5_active_c32", 32'(actv[32]), 1);
    chk("t5_byte4",      32'(get_byte(4)), 32'h7C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/paralelo_serial_tx.md
PARALELO_SERIAL_TX -- requirements
Module: paralelo_serial_tx

Interface
REQ-001 Parameter SYNC_BYTES, default 4, SHALL set the number of comma bytes sent after reset before data is accepted (legal range 1..7).
REQ-002 Parameter COMMA, default 8'hBC, SHALL be the alignment character.
REQ-003 Parameter IDLE_CH, default 8'h7C, SHALL be the idle filler character.
REQ-004 clk_32f  input  1  SHALL be the single bit clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be asynchronous and active-high.
REQ-006 data_in  input  8  SHALL carry the parallel byte offered for transmission.
REQ-007 valid_in  input  1  SHALL indicate that data_in holds a byte to send.
REQ-008 data_out  output  1  SHALL be the registered serial bit stream, MSB first.
REQ-009 ack  output  1  SHALL indicate that data_in is consumed at the end of the current cycle.
REQ-010 active  output  1  SHALL be high while the FSM is in ACTIVE.
REQ-011 idle_tx  output  1  SHALL be high while the byte being serialized is an IDLE_CH filler.

Function
REQ-012 The block SHALL hold the byte being serialized (cur_byte), a 3-bit bit counter (bit_cnt), a 3-bit sync counter (sync_cnt) and a 2-state FSM {SYNC, ACTIVE}.
REQ-013 On every non-reset edge, data_out SHALL be loaded with cur_byte[7-bit_cnt], and bit_cnt SHALL increment and wrap 7->0.
REQ-014 A byte boundary SHALL be any edge where bit_cnt==7; only at a boundary SHALL cur_byte be reloaded, so bit 0 of one byte is followed by bit 7 of the next with no gap.
REQ-015 In SYNC at a boundary with sync_cnt<SYNC_BYTES: cur_byte<=COMMA, sync_cnt increments, FSM stays in SYNC.
REQ-016 In SYNC at a boundary with sync_cnt==SYNC_BYTES: the FSM SHALL move to ACTIVE and cur_byte SHALL be chosen by the ACTIVE rule (REQ-017) at that same edge.
REQ-017 ACTIVE rule at a boundary: if valid_in==1 then cur_byte<=data_in; otherwise cur_byte<=IDLE_CH.
REQ-018 ack SHALL be combinational: ack = valid_in & (bit_cnt==7) & (ACTIVE, or SYNC with sync_cnt==SYNC_BYTES). It SHALL be high for exactly one cycle per consumed byte.
REQ-019 valid_in/data_in SHALL be ignored while ack==0; the source SHALL hold data_in stable until it sees ack.
REQ-020 Data bytes equal to COMMA or IDLE_CH SHALL be sent unchanged, with idle_tx=0 (no escaping).
REQ-021 idle_tx SHALL be registered, updated at each boundary to 1 if and only if IDLE_CH was loaded by the ACTIVE rule.
REQ-022 active SHALL be registered and SHALL stay high until reset once ACTIVE is entered; there is no return to SYNC except through reset.

Reset
REQ-023 While reset==1: data_out=0, ack=0, active=0, idle_tx=0, bit_cnt=0, sync_cnt=1, cur_byte=COMMA, FSM=SYNC.
REQ-024 Assertion mid-byte SHALL take effect immediately, without waiting for a clock edge; the partial byte is discarded.
REQ-025 The first rising edge after deassertion SHALL drive data_out with COMMA bit 7.

Verification
REQ-026 Reset, then valid_in=0 for 96 cycles -> data_out = 4x 8'hBC then 8x 8'h7C MSB first; active rises at cycle 32; idle_tx=1 from byte 5.
REQ-027 valid_in=1, data_in=8'hA5 held from reset -> ack is high only at cycle 31 (bit_cnt==7, last BC byte); bits 33-40 are 1,0,1,0,0,1,0,1.
REQ-028 Back-to-back bytes 8'h01, 8'hFF, 8'h3C with valid_in=1 and data_in updated after each ack -> contiguous 24-bit stream, one ack per byte, idle_tx=0 throughout.
REQ-029 valid_in toggles 1/0 on alternate byte slots in ACTIVE -> data and 8'h7C bytes alternate; idle_tx follows each 8'h7C slot.
REQ-030 Data 8'hBC sent in ACTIVE -> transmitted verbatim, idle_tx=0, active stays 1.
REQ-031 reset pulsed at bit_cnt==4 of a data byte -> outputs clear with no clock edge; restart with 4x 8'hBC and active=0 until re-sync.
